lsu_mem_stage: RTL and testbench

- Memory-access stage of the multi-cycle core. It sits directly downstream of the ALU and consumes the ALU result as the effective address for LB/LW/SB/SW.
- Issues one request per instruction to the data-memory port using a req/gnt + rvalid handshake.
- Performs byte-lane steering and LB sign extension.
- Signals completion to the control FSM with a one-cycle pulse.

---
 rtl/params_pkg.sv | 35 +++
 rtl/lsu_lane_align.sv | 38 +++
 rtl/lsu_mem_stage.sv | 130 +++++++++++++
 tb/tb_lsu_mem_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/params_pkg.sv
// Shared core parameters and types: datapath width, opcode encoding and the
// load/store unit's state and funct3 definitions.
package params_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_ALU    = 7'b0110011,
        OP_ALUI   = 7'b0010011,
        OP_BRANCH = 7'b1100011
    } opcode_t;

    localparam logic [2:0] F3_BYTE = 3'b000;
    localparam logic [2:0] F3_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        DONE
    } lsu_state_t;

    // Legal accesses are byte or naturally aligned word loads/stores.
    function automatic logic lsu_access_legal(opcode_t op, logic [2:0] funct3, logic [1:0] lane);
        logic op_ok;
        logic size_ok;
        op_ok   = (op == OP_LOAD) || (op == OP_STORE);
        size_ok = (funct3 == F3_BYTE) || ((funct3 == F3_WORD) && (lane == 2'b00));
        return op_ok && size_ok;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the memory stage: store byte enables / write data and
// load extraction with sign extension, little-endian lane = addr[1:0].
module lsu_lane_align #(
    parameter  int DATA_WIDTH = params_pkg::DATA_WIDTH,
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            lane,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [BE_WIDTH-1:0]   be,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data
);
    import params_pkg::*;

    logic [7:0] byte_sel;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        be        = '0;
        wdata     = store_data;
        load_data = rdata;
        byte_sel  = rdata[{lane, 3'b000} +: 8];
        case (funct3)
            F3_BYTE: begin
                be        = BE_WIDTH'(1) << lane;
                wdata     = {BE_WIDTH{store_data[7:0]}};
                load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            end
            F3_WORD: begin
                be = '1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: one req/gnt + rvalid transaction per LOAD/STORE, with a
// one-cycle done pulse (err for misaligned/unsupported accesses, no memory traffic).
module lsu_mem_stage #(
    parameter  int DATA_WIDTH = params_pkg::DATA_WIDTH,
    parameter  int ADDR_WIDTH = 32,
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  params_pkg::opcode_t     opcode_i,
    input  logic [2:0]              funct3_i,
    input  logic [DATA_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   store_data_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [DATA_WIDTH-1:0]   load_data_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [BE_WIDTH-1:0]     mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
    import params_pkg::*;

    lsu_state_t            state_q, state_d;
    logic                  is_store_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] store_data_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] load_data_q;

    logic                  legal;
    logic                  accept;
    logic                  capture;
    logic [BE_WIDTH-1:0]   be_al;
    logic [DATA_WIDTH-1:0] wdata_al;
    logic [DATA_WIDTH-1:0] load_al;

    assign legal   = lsu_access_legal(opcode_i, funct3_i, addr_i[1:0]);
    assign accept  = (state_q == IDLE) && start_i;
    assign capture = ((state_q == REQ) && !is_store_q && mem_gnt_i && mem_rvalid_i) ||
                     ((state_q == WAIT_R) && mem_rvalid_i);

    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .funct3     (funct3_q),
        .lane       (addr_q[1:0]),
        .store_data (store_data_q),
        .rdata      (mem_rdata_i),
        .be         (be_al),
        .wdata      (wdata_al),
        .load_data  (load_al)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start_i) state_d = legal ? REQ : DONE;
            REQ: begin
                if (mem_gnt_i) begin
                    if (is_store_q || mem_rvalid_i) state_d = DONE;
                    else                            state_d = WAIT_R;
                end
            end
            WAIT_R: if (mem_rvalid_i) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            store_data_q <= '0;
            err_q        <= 1'b0;
            load_data_q  <= '0;
        end else begin
            if (accept) begin
                is_store_q   <= (opcode_i == OP_STORE);
                funct3_q     <= funct3_i;
                addr_q       <= addr_i[ADDR_WIDTH-1:0];
                store_data_q <= store_data_i;
                err_q        <= !legal;
            end
            if (capture) load_data_q <= load_al;
        end
    end

    // Memory-side outputs are only driven while requesting; zero otherwise.
    always_comb begin
        busy_o      = (state_q != IDLE);
        done_o      = 1'b0;
        err_o       = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        case (state_q)
            REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = is_store_q;
                mem_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                mem_be_o    = be_al;
                mem_wdata_o = wdata_al;
            end
            DONE: begin
                done_o = 1'b1;
                err_o  = err_q;
            end
            default: ;
        endcase
    end

    assign load_data_o = load_data_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: a transaction-level reference model
// compared every cycle, plus directed vectors with hand-computed expectations.
module tb_lsu_mem_stage;
    import params_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        start_i = 1'b0;
    opcode_t     opcode_i = OP_LOAD;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] addr_i = '0;
    logic [31:0] store_data_i = '0;
    logic        busy_o, done_o, err_o;
    logic [31:0] load_data_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    always #5 clk_i = ~clk_i;

    lsu_mem_stage dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .opcode_i     (opcode_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .store_data_i (store_data_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .load_data_o  (load_data_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    int total = 0;
    int bad   = 0;
    int n_hs  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction tracked by its progress.
    // progress: 0 = none, 1 = requesting, 2 = awaiting read data, 3 = completing
    int          m_prog  = 0;
    bit          m_store = 1'b0;
    bit          m_byte  = 1'b0;
    bit          m_err   = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_data  = '0;
    logic [31:0] m_load  = '0;

    function automatic logic [31:0] load_value(bit is_byte, logic [31:0] a, logic [31:0] rd);
        logic [31:0] b;
        if (!is_byte) return rd;
        b = (rd >> (8 * (a % 4))) & 32'hFF;
        return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
    endfunction

    always @(negedge rst_ni) begin
        m_prog = 0;
        m_err  = 1'b0;
        m_load = '0;
    end

    always @(posedge clk_i) begin
        if (rst_ni) begin
            case (m_prog)
                0: if (start_i) begin
                    m_store = (opcode_i == OP_STORE);
                    m_byte  = (funct3_i == 3'b000);
                    m_addr  = addr_i;
                    m_data  = store_data_i;
                    m_err   = !(((opcode_i == OP_LOAD) || (opcode_i == OP_STORE)) &&
                                ((funct3_i == 3'b000) || ((funct3_i == 3'b010) && (addr_i % 4 == 0))));
                    m_prog  = m_err ? 3 : 1;
                end
                1: if (mem_gnt_i) begin
                    if (m_store) m_prog = 3;
                    else if (mem_rvalid_i) begin
                        m_load = load_value(m_byte, m_addr, mem_rdata_i);
                        m_prog = 3;
                    end else m_prog = 2;
                end
                2: if (mem_rvalid_i) begin
                    m_load = load_value(m_byte, m_addr, mem_rdata_i);
                    m_prog = 3;
                end
                default: m_prog = 0;
            endcase
        end
    end

    always @(negedge clk_i) begin
        if (mem_req_o && mem_gnt_i) n_hs++;
        check("m_busy", busy_o, m_prog != 0);
        check("m_done", done_o, m_prog == 3);
        check("m_err",  err_o,  (m_prog == 3) && m_err);
        check("m_req",  mem_req_o, m_prog == 1);
        check("m_load", load_data_o, m_load);
        if (m_prog == 1) begin
            check("m_we",    mem_we_o, m_store);
            check("m_addr",  mem_addr_o, m_addr & ~32'h3);
            check("m_be",    mem_be_o, m_byte ? (32'h1 << (m_addr % 4)) : 32'hF);
            check("m_wdata", mem_wdata_o, m_byte ? (m_data & 32'hFF) * 32'h0101_0101 : m_data);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input opcode_t op, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        start_i      = 1'b1;
        opcode_i     = op;
        funct3_i     = f3;
        addr_i       = a;
        store_data_i = d;
        tick();
        start_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  busy_o, 0);
        check({tag, "_done"},  done_o, 0);
        check({tag, "_err"},   err_o, 0);
        check({tag, "_load"},  load_data_o, 0);
        check({tag, "_req"},   mem_req_o, 0);
        check({tag, "_we"},    mem_we_o, 0);
        check({tag, "_addr"},  mem_addr_o, 0);
        check({tag, "_be"},    mem_be_o, 0);
        check({tag, "_wdata"}, mem_wdata_o, 0);
    endtask

    int hs0;

    initial begin
        #1 rst_ni = 1'b0;
        #1 check_all_zero("rst");
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // SW with grant withheld for three cycles
        issue(OP_STORE, 3'b010, 32'h0000_1008, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            check("sw_req",   mem_req_o, 1);
            check("sw_we",    mem_we_o, 1);
            check("sw_addr",  mem_addr_o, 32'h0000_1008);
            check("sw_be",    mem_be_o, 4'b1111);
            check("sw_wdata", mem_wdata_o, 32'hDEAD_BEEF);
            tick();
        end
        mem_gnt_i = 1'b1;
        check("sw_req_gnt", mem_req_o, 1);
        tick();
        mem_gnt_i = 1'b0;
        check("sw_done", done_o, 1);
        check("sw_err",  err_o, 0);
        tick();
        check("sw_done_once", done_o, 0);

        // SB to lane 3
        issue(OP_STORE, 3'b000, 32'h0000_1003, 32'h0000_00A5);
        mem_gnt_i = 1'b1;
        check("sb_be",    mem_be_o, 4'b1000);
        check("sb_wdata", mem_wdata_o, 32'hA5A5_A5A5);
        check("sb_addr",  mem_addr_o, 32'h0000_1000);
        tick();
        mem_gnt_i = 1'b0;
        check("sb_done", done_o, 1);
        check("sb_err",  err_o, 0);
        tick();

        // LB lane 1 (negative) and lane 2 (positive), rvalid two cycles after gnt
        issue(OP_LOAD, 3'b000, 32'h0000_2001, 32'h0);
        mem_gnt_i = 1'b1;
        check("lb1_we", mem_we_o, 0);
        check("lb1_be", mem_be_o, 4'b0010);
        tick();
        mem_gnt_i = 1'b0;
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234_80FF;
        tick();
        mem_rvalid_i = 1'b0;
        check("lb1_done", done_o, 1);
        check("lb1_data", load_data_o, 32'hFFFF_FF80);
        tick();
        issue(OP_LOAD, 3'b000, 32'h0000_2002, 32'h0);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        tick();
        mem_rvalid_i = 1'b1;
        tick();
        mem_rvalid_i = 1'b0;
        check("lb2_data", load_data_o, 32'h0000_0034);
        tick();

        // stray rvalid while idle must not disturb load data
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0BAD_0BAD;
        tick();
        mem_rvalid_i = 1'b0;
        check("stray_rvalid", load_data_o, 32'h0000_0034);

        // illegal accesses: done+err next cycle, no memory traffic
        hs0 = n_hs;
        issue(OP_LOAD, 3'b010, 32'h0000_3002, 32'h0);
        check("lw_mis_req",  mem_req_o, 0);
        check("lw_mis_done", done_o, 1);
        check("lw_mis_err",  err_o, 1);
        check("lw_mis_load", load_data_o, 32'h0000_0034);
        tick();
        issue(OP_LOAD, 3'b001, 32'h0000_3000, 32'h0);
        check("f3_001_done", done_o, 1);
        check("f3_001_err",  err_o, 1);
        tick();
        issue(OP_ALU, 3'b010, 32'h0000_3000, 32'h0);
        check("op_alu_err", err_o, 1);
        tick();
        issue(OP_STORE, 3'b010, 32'h0000_3001, 32'h5555_5555);
        check("sw_mis_err", err_o, 1);
        tick();
        check("err_no_traffic", n_hs - hs0, 0);
        check("err_load_kept", load_data_o, 32'h0000_0034);

        // LW with gnt and rvalid together; starts while busy are ignored
        hs0 = n_hs;
        issue(OP_LOAD, 3'b010, 32'h0000_4000, 32'h0);
        start_i      = 1'b1;
        addr_i       = 32'h0000_4004;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE_BABE;
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        check("lw_fast_done", done_o, 1);
        check("lw_fast_data", load_data_o, 32'hCAFE_BABE);
        tick();
        start_i = 1'b0;
        check("busy_start_ignored", busy_o, 0);
        tick();
        tick();
        check("single_req", n_hs - hs0, 1);

        // asynchronous reset while waiting for read data
        issue(OP_LOAD, 3'b010, 32'h0000_5000, 32'h0);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        check("wait_busy", busy_o, 1);
        #2 rst_ni = 1'b0;
        #1 check_all_zero("arst");
        tick();
        rst_ni = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1111_2222;
        tick();
        mem_rvalid_i = 1'b0;
        check("post_rst_load", load_data_o, 32'h0);
        check("post_rst_busy", busy_o, 0);
        issue(OP_STORE, 3'b010, 32'h0000_6000, 32'h0123_4567);
        mem_gnt_i = 1'b1;
        check("post_rst_addr", mem_addr_o, 32'h0000_6000);
        tick();
        mem_gnt_i = 1'b0;
        check("post_rst_done", done_o, 1);
        check("post_rst_err",  err_o, 0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
